rr_bus_arbiter: RTL and testbench



---
 rtl/rr_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_rr_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for the shared bus: one-hot grant, ack window, hold watchdog, turnaround.
// Grant is registered 1 cycle after a sampled request; no back-pressure, masters hold m_reqs as a level.
module rr_bus_arbiter #(
   parameter int NUM_MASTERS = 12,
   parameter int MID_WIDTH   = 4,
   parameter int ACK_WAIT    = 4,
   parameter int HOLD_LEN    = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NUM_MASTERS-1:0] m_reqs,
   input  logic                   bus_util,
   output logic [NUM_MASTERS-1:0] m_grants,
   output logic [MID_WIDTH-1:0]   mid_current,
   output logic [1:0]             state,
   output logic                   no_ack,
   output logic                   timeout
);

   localparam int ACK_W = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;
   localparam int CNT_W = (HOLD_LEN > ACK_W) ? HOLD_LEN : ACK_W;
   localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_WAIT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'({HOLD_LEN{1'b1}});

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_BUSY    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t                 r_state;
   logic [NUM_MASTERS-1:0] r_grants;
   logic [MID_WIDTH-1:0]   r_mid;
   logic [MID_WIDTH-1:0]   r_last;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_no_ack;
   logic                   r_timeout;

   logic                   w_found;
   logic [MID_WIDTH-1:0]   w_win;
   logic                   w_req_held;

   // Two passes give the rotating priority: indices above last first, then wrap to 0..last.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!w_found && m_reqs[i] && (i > int'(r_last))) begin
            w_found = 1'b1;
            w_win   = MID_WIDTH'(i);
         end
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!w_found && m_reqs[i] && (i <= int'(r_last))) begin
            w_found = 1'b1;
            w_win   = MID_WIDTH'(i);
         end
      end
   end

   assign w_req_held = |(m_reqs & r_grants);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_grants  <= '0;
         r_mid     <= '0;
         r_last    <= MID_WIDTH'(NUM_MASTERS - 1);
         r_cnt     <= '0;
         r_no_ack  <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_no_ack  <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grants <= NUM_MASTERS'(1) << w_win;
                  r_mid    <= w_win;
                  r_cnt    <= '0;
                  r_state  <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (bus_util) begin
                  r_cnt   <= '0;
                  r_state <= S_BUSY;
               end else if (!w_req_held) begin
                  r_grants <= '0;
                  r_last   <= r_mid;
                  r_state  <= S_RELEASE;
               end else if (r_cnt == ACK_LAST) begin
                  r_grants <= '0;
                  r_no_ack <= 1'b1;
                  r_last   <= r_mid;
                  r_state  <= S_RELEASE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_BUSY: begin
               if (!bus_util) begin
                  r_grants <= '0;
                  r_last   <= r_mid;
                  r_state  <= S_RELEASE;
               end else if (r_cnt == HOLD_LAST) begin
                  r_grants  <= '0;
                  r_timeout <= 1'b1;
                  r_last    <= r_mid;
                  r_state   <= S_RELEASE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               // A revoked master may still be driving the bus; wait for it to let go.
               if (!bus_util) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign m_grants    = r_grants;
   assign mid_current = r_mid;
   assign state       = r_state;
   assign no_ack      = r_no_ack;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter: reset, round-robin order, ack window, watchdog, drop, async reset.
module tb_rr_bus_arbiter;
   logic        clk;
   logic        rstn;
   logic [11:0] m_reqs;
   logic        bus_util;
   logic [11:0] m_grants;
   logic [3:0]  mid_current;
   logic [1:0]  state;
   logic        no_ack;
   logic        timeout;

   int total;
   int bad;

   rr_bus_arbiter #(
      .NUM_MASTERS(12),
      .MID_WIDTH  (4),
      .ACK_WAIT   (4),
      .HOLD_LEN   (4)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .m_reqs     (m_reqs),
      .bus_util   (bus_util),
      .m_grants   (m_grants),
      .mid_current(mid_current),
      .state      (state),
      .no_ack     (no_ack),
      .timeout    (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn     = 1'b0;
      m_reqs   = '0;
      bus_util = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rstn     = 1'b0;
      m_reqs   = '0;
      bus_util = 1'b0;
      #3;
      total++;
      if (m_grants !== 12'h000) begin bad++; $display("FAIL reset_grants got=%h want=000", m_grants); end
      total++;
      if (mid_current !== 4'd0) begin bad++; $display("FAIL reset_mid got=%0d want=0", mid_current); end
      total++;
      if (state !== 2'd0 || no_ack !== 1'b0 || timeout !== 1'b0) begin
         bad++; $display("FAIL reset_flags state=%0d no_ack=%b timeout=%b want 0/0/0", state, no_ack, timeout);
      end
      tick();
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      m_reqs = 12'h004;
      tick();
      total++;
      if (m_grants !== 12'h004 || mid_current !== 4'd2 || state !== 2'd1) begin
         bad++; $display("FAIL single_grant grants=%h mid=%0d state=%0d want 004/2/1", m_grants, mid_current, state);
      end
      bus_util = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      total++;
      if (m_grants !== 12'h004 || state !== 2'd2) begin
         bad++; $display("FAIL single_busy grants=%h state=%0d want 004/2", m_grants, state);
      end
      bus_util = 1'b0;
      m_reqs   = 12'h000;
      tick();
      total++;
      if (m_grants !== 12'h000 || state !== 2'd3) begin
         bad++; $display("FAIL single_release grants=%h state=%0d want 000/3", m_grants, state);
      end
      tick();
      total++;
      if (state !== 2'd0 || mid_current !== 4'd2) begin
         bad++; $display("FAIL single_idle state=%0d mid=%0d want 0/2", state, mid_current);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] order [6];
      order = '{4'd2, 4'd4, 4'd5, 4'd2, 4'd4, 4'd5};
      do_reset();
      m_reqs = 12'h034;
      for (int t = 0; t < 6; t++) begin
         tick();
         total++;
         if (m_grants !== (12'h001 << order[t]) || mid_current !== order[t]) begin
            bad++; $display("FAIL rr_order[%0d] grants=%h mid=%0d want mid=%0d", t, m_grants, mid_current, order[t]);
         end
         bus_util = 1'b1;
         tick();
         tick();
         tick();
         bus_util = 1'b0;
         tick();
         tick();
         total++;
         if (m_grants !== 12'h000 || state !== 2'd0) begin
            bad++; $display("FAIL rr_gap[%0d] grants=%h state=%0d want 000/0", t, m_grants, state);
         end
      end
   endtask

   task automatic test_no_ack();
      do_reset();
      m_reqs = 12'h030;
      tick();
      total++;
      if (m_grants !== 12'h010) begin bad++; $display("FAIL noack_grant got=%h want=010", m_grants); end
      for (int i = 0; i < 3; i++) tick();
      total++;
      if (m_grants !== 12'h010 || no_ack !== 1'b0) begin
         bad++; $display("FAIL noack_window grants=%h no_ack=%b want 010/0", m_grants, no_ack);
      end
      tick();
      total++;
      if (m_grants !== 12'h000 || no_ack !== 1'b1 || state !== 2'd3) begin
         bad++; $display("FAIL noack_pulse grants=%h no_ack=%b state=%0d want 000/1/3", m_grants, no_ack, state);
      end
      tick();
      total++;
      if (no_ack !== 1'b0 || state !== 2'd0) begin
         bad++; $display("FAIL noack_single no_ack=%b state=%0d want 0/0", no_ack, state);
      end
      tick();
      total++;
      if (m_grants !== 12'h020 || mid_current !== 4'd5) begin
         bad++; $display("FAIL noack_next grants=%h mid=%0d want 020/5", m_grants, mid_current);
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      m_reqs = 12'h004;
      tick();
      bus_util = 1'b1;
      tick();
      for (int i = 0; i < 15; i++) tick();
      total++;
      if (m_grants !== 12'h004 || timeout !== 1'b0) begin
         bad++; $display("FAIL wd_hold grants=%h timeout=%b want 004/0", m_grants, timeout);
      end
      tick();
      total++;
      if (m_grants !== 12'h000 || timeout !== 1'b1 || state !== 2'd3) begin
         bad++; $display("FAIL wd_revoke grants=%h timeout=%b state=%0d want 000/1/3", m_grants, timeout, state);
      end
      for (int i = 0; i < 12; i++) tick();
      total++;
      if (m_grants !== 12'h000 || timeout !== 1'b0 || state !== 2'd3) begin
         bad++; $display("FAIL wd_drain grants=%h timeout=%b state=%0d want 000/0/3", m_grants, timeout, state);
      end
      bus_util = 1'b0;
      tick();
      total++;
      if (state !== 2'd0) begin bad++; $display("FAIL wd_idle state=%0d want 0", state); end
      tick();
      total++;
      if (m_grants !== 12'h004) begin bad++; $display("FAIL wd_regrant got=%h want=004", m_grants); end
   endtask

   task automatic test_drop();
      do_reset();
      m_reqs = 12'h004;
      tick();
      m_reqs = 12'h000;
      tick();
      total++;
      if (m_grants !== 12'h000 || no_ack !== 1'b0 || state !== 2'd3) begin
         bad++; $display("FAIL drop_release grants=%h no_ack=%b state=%0d want 000/0/3", m_grants, no_ack, state);
      end
      tick();
      m_reqs = 12'h004;
      tick();
      m_reqs   = 12'h000;
      bus_util = 1'b1;
      tick();
      total++;
      if (m_grants !== 12'h004 || state !== 2'd2) begin
         bad++; $display("FAIL drop_util_busy grants=%h state=%0d want 004/2", m_grants, state);
      end
      tick();
      total++;
      if (m_grants !== 12'h004 || state !== 2'd2) begin
         bad++; $display("FAIL drop_busy_held grants=%h state=%0d want 004/2", m_grants, state);
      end
      bus_util = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      m_reqs = 12'h004;
      tick();
      bus_util = 1'b1;
      tick();
      tick();
      #2;
      rstn = 1'b0;
      #1;
      total++;
      if (m_grants !== 12'h000 || state !== 2'd0 || timeout !== 1'b0) begin
         bad++; $display("FAIL async_reset grants=%h state=%0d timeout=%b want 000/0/0", m_grants, state, timeout);
      end
      bus_util = 1'b0;
      m_reqs   = 12'h801;
      @(negedge clk);
      rstn = 1'b1;
      tick();
      total++;
      if (m_grants !== 12'h001 || mid_current !== 4'd0) begin
         bad++; $display("FAIL async_first grants=%h mid=%0d want 001/0", m_grants, mid_current);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rstn     = 1'b0;
      m_reqs   = '0;
      bus_util = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_no_ack();
      test_watchdog();
      test_drop();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
